// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx -- 8N1 serial transmitter
//
// Sends one start bit (0), eight data bits LSB first and one stop bit (1) on
// an idle-high line. Each bit lasts CLKS_PER_BIT clock cycles. Bytes come in
// over a ready/valid handshake. The last cycle of a stop bit can accept the
// next byte, so back-to-back frames leave no idle gap on the line.
//
// Optional feature macro: UART_TX_BREAK_EN
//   When defined, this adds the send_break input and the BREAK/MARK states.
//   A break holds the line low for at least BREAK_BITS bit periods. It is then
//   followed by one high bit period (MARK) before the block returns to IDLE.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (1..65535)
//   BREAK_BITS    minimum break length in bit periods (break build only)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   data[7:0]   in   byte to send, sampled only on a handshake
//   data_valid  in   data holds a byte to send
//   data_ready  out  block accepts a byte this cycle
//   signal      out  registered serial line, idle high
//   busy        out  high while a frame (or break) is on the line
//   send_break  in   request a line break (UART_TX_BREAK_EN only)
//
// Handshake: a byte is transferred at a rising edge where data_valid and
// data_ready are both high. data_ready is decoded from the state and the baud
// counter only. It never looks at data_valid, so the sender may wait on it
// freely. Holding data_valid low transfers nothing.
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned BREAK_BITS   = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       signal,
`ifdef UART_TX_BREAK_EN
    input  logic       send_break,
`endif
    output logic       busy
);

    if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 ||
        BREAK_BITS < 1 || BREAK_BITS > 65535) begin : g_bad_param
        $error("uart_tx: CLKS_PER_BIT or BREAK_BITS out of range 1..65535");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK = 3'd4;
    localparam logic [2:0] ST_MARK  = 3'd5;
    localparam logic [15:0] BREAK_LAST = 16'(BREAK_BITS - 1);
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        signal_q, signal_d;
    logic        busy_q, busy_d;
`ifdef UART_TX_BREAK_EN
    logic [15:0] brk_cnt_q, brk_cnt_d;
`endif

    logic baud_wrap;

    // The baud counter wrapping marks the last cycle of the current bit period.
    assign baud_wrap = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        signal_d   = 1'b1;
        data_ready = 1'b0;
        baud_d     = baud_wrap ? 16'd0 : (baud_q + 16'd1);
`ifdef UART_TX_BREAK_EN
        brk_cnt_d  = brk_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                signal_d = 1'b1;
                // The counter is held at 0 so that the next bit period starts aligned.
                baud_d   = 16'd0;
`ifdef UART_TX_BREAK_EN
                data_ready = ~send_break;
                if (send_break) begin
                    state_d   = ST_BREAK;
                    brk_cnt_d = 16'd0;
                end else
`else
                data_ready = 1'b1;
`endif
                if (data_valid) begin
                    shift_d = data;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                signal_d = 1'b0;
                if (baud_wrap) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end

            ST_DATA: begin
                signal_d = shift_q[0];
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                signal_d = 1'b1;
                // The last stop cycle can accept the next byte, which gives a gap-free stream.
                if (baud_wrap) begin
`ifdef UART_TX_BREAK_EN
                    data_ready = ~send_break;
                    if (send_break) begin
                        state_d   = ST_BREAK;
                        brk_cnt_d = 16'd0;
                    end else
`else
                    data_ready = 1'b1;
`endif
                    if (data_valid) begin
                        shift_d = data;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                signal_d = 1'b0;
                // brk_cnt counts completed break periods and saturates at BREAK_BITS-1.
                // Leaving BREAK needs the minimum length and a released request.
                if (baud_wrap) begin
                    if (brk_cnt_q == BREAK_LAST) begin
                        if (!send_break) begin
                            state_d = ST_MARK;
                        end
                    end else begin
                        brk_cnt_d = brk_cnt_q + 16'd1;
                    end
                end
            end

            ST_MARK: begin
                // One high bit period lets the receiver leave its own break state.
                signal_d = 1'b1;
                if (baud_wrap) begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d  = ST_IDLE;
                signal_d = 1'b1;
                baud_d   = 16'd0;
            end
        endcase
    end

    // busy is registered with the line, so it covers exactly the cycles
    // when the frame is visible on signal.
    assign busy_d = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            shift_q   <= 8'd0;
            idx_q     <= 3'd0;
            signal_q  <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            signal_q  <= signal_d;
            busy_q    <= busy_d;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= brk_cnt_d;
`endif
        end
    end

    assign signal = signal_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx
//
// There are three transmitter instances: channel 0 uses CLKS_PER_BIT=1,
// channel 1 uses 4 and channel 2 uses 2. Each channel has a reference model
// that keeps a queue of expected line values, one per clock edge. A
// handshake appends the whole frame, and the model treats the block as ready
// when at most one expected value is still pending.
// ----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NCH = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_w;
    logic [2:0] valid_w;
    logic [2:0] ready_w;
    logic [2:0] signal_w;
    logic [2:0] busy_w;
    logic [7:0] data_w [NCH];
`ifdef UART_TX_BREAK_EN
    logic [2:0] brk_w;
`endif
    bit mon_en [NCH];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic [9:0] frame;   // line bits in transmission order, MSB first
    } vec_t;

    vec_t vecs [6];

    // ---------------- helpers ----------------
    task automatic check(input string name, input int ch, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, got, exp, $time);
        end
    endtask

    function automatic int cpb_of(input int ch);
        case (ch)
            0:       return 1;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    // Bit i of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    // ---------------- DUTs and reference models ----------------
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int CPB = (g == 0) ? 1 : ((g == 1) ? 4 : 2);

        uart_tx #(.CLKS_PER_BIT(CPB), .BREAK_BITS(11)) u_dut (
            .clk        (clk),
            .reset      (rst_w[g]),
            .data       (data_w[g]),
            .data_valid (valid_w[g]),
            .data_ready (ready_w[g]),
            .signal     (signal_w[g]),
`ifdef UART_TX_BREAK_EN
            .send_break (brk_w[g]),
`endif
            .busy       (busy_w[g])
        );

        logic [0:0] exp_q [$];
        logic pend;
        logic e_sig;
        logic e_busy;

        always begin
            @(negedge clk);
            #2;
            pend = 1'b0;
            if (mon_en[g] && !rst_w[g]) begin
                check("mon_ready", g, 32'(ready_w[g]), 32'(exp_q.size() <= 1));
                pend = valid_w[g] && (exp_q.size() <= 1);
            end
            @(posedge clk);
            if (!mon_en[g]) begin
                exp_q.delete();
            end else begin
                if (rst_w[g]) begin
                    exp_q.delete();
                    e_sig  = 1'b1;
                    e_busy = 1'b0;
                end else begin
                    e_busy = (exp_q.size() != 0);
                    e_sig  = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
                    if (pend) begin
                        for (int i = 0; i < 10; i++)
                            for (int c = 0; c < CPB; c++)
                                exp_q.push_back(frame_bit(data_w[g], i));
                    end
                end
                #1;
                check("mon_signal", g, 32'(signal_w[g]), 32'(e_sig));
                check("mon_busy", g, 32'(busy_w[g]), 32'(e_busy));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input int ch, input logic [7:0] b, input logic [9:0] fr);
        int cpb = cpb_of(ch);
        int t = 0;
        @(negedge clk);
        data_w[ch]  = b;
        valid_w[ch] = 1'b1;
        while (!ready_w[ch] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("frame_ready_timeout", ch, 32'd0, 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 10 * cpb + 1; k++) begin
            @(negedge clk);
            valid_w[ch] = 1'b0;
            data_w[ch]  = 8'($urandom);
            #1;
            check("frame_ready", ch, 32'(ready_w[ch]), 32'(k >= 10 * cpb));
            @(posedge clk);
            #1;
            if (k <= 10 * cpb) begin
                check("frame_line", ch, 32'(signal_w[ch]), 32'(fr[9 - (k - 1) / cpb]));
                check("frame_busy", ch, 32'(busy_w[ch]), 32'd1);
            end else begin
                check("after_line", ch, 32'(signal_w[ch]), 32'd1);
                check("after_busy", ch, 32'(busy_w[ch]), 32'd0);
            end
        end
    endtask

    task automatic back_to_back();
        logic [19:0] exp = 20'b0000000001_0111111111;
        int hs = 0;
        logic p;
        @(negedge clk);
        data_w[0]  = 8'h00;
        valid_w[0] = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            #1 p = valid_w[0] && ready_w[0];
            @(posedge clk);
            if (p) hs++;
            #1;
            if (c > 0) begin
                check("b2b_line", 0, 32'(signal_w[0]), 32'(exp[20 - c]));
                check("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
            end
            @(negedge clk);
            if (hs == 1) data_w[0] = 8'hFF;
            if (hs >= 2) valid_w[0] = 1'b0;
        end
        check("b2b_handshakes", 0, 32'(hs), 32'd2);
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        data_w[0]  = 8'h3C;
        valid_w[0] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            valid_w[0] = 1'b0;
            if (k == 6) rst_w[0] = 1'b1;
            if (k == 8) rst_w[0] = 1'b0;
            @(posedge clk);
            #1;
            if (k <= 5) begin
                check("rst_pre_line", 0, 32'(signal_w[0]), 32'(frame_bit(8'h3C, k - 1)));
            end else begin
                check("rst_line", 0, 32'(signal_w[0]), 32'd1);
                check("rst_busy", 0, 32'(busy_w[0]), 32'd0);
            end
        end
        send_frame(0, 8'h55, 10'b0101010101);
    endtask

    task automatic backpressure();
        logic [7:0] sent [2];
        int hs = 0;
        int t = 0;
        logic p;
        sent[0] = 8'h00;
        sent[1] = 8'h00;
        @(negedge clk);
        data_w[1]  = 8'h12;
        valid_w[1] = 1'b1;
        while (hs < 2 && t < 200) begin
            #1 p = valid_w[1] && ready_w[1];
            if (p) sent[hs] = data_w[1];
            @(posedge clk);
            if (p) hs++;
            @(negedge clk);
            t++;
            if (hs >= 1) data_w[1] = 8'($urandom);
        end
        valid_w[1] = 1'b0;
        check("bp_handshakes", 1, 32'(hs), 32'd2);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            #1;
            check("bp_line", 1, 32'(signal_w[1]),
                  32'((k <= 40) ? frame_bit(sent[1], (k - 1) / 4) : 1'b1));
            check("bp_busy", 1, 32'(busy_w[1]), 32'(k <= 40));
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic break_pulse();
        @(negedge clk);
        brk_w[2] = 1'b1;
        #1 check("brk_ready", 2, 32'(ready_w[2]), 32'd0);
        @(posedge clk);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            brk_w[2] = 1'b0;
            @(posedge clk);
            #1;
            check("brk_line", 2, 32'(signal_w[2]), 32'(k > 22));
            check("brk_busy", 2, 32'(busy_w[2]), 32'(k <= 24));
        end
    endtask

    task automatic break_mid_frame();
        logic [9:0] fr = 10'b0101001011;
        @(negedge clk);
        data_w[2]  = 8'hA5;
        valid_w[2] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            valid_w[2] = 1'b0;
            brk_w[2]   = (k >= 9 && k <= 25);
            #1;
            if (brk_w[2]) check("brkm_ready", 2, 32'(ready_w[2]), 32'd0);
            @(posedge clk);
            #1;
            if (k <= 20)
                check("brkm_frame", 2, 32'(signal_w[2]), 32'(fr[9 - (k - 1) / 2]));
            else
                check("brkm_line", 2, 32'(signal_w[2]), 32'(k > 42));
            check("brkm_busy", 2, 32'(busy_w[2]), 32'(k <= 44));
        end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_w   = 3'b111;
        valid_w = 3'b000;
`ifdef UART_TX_BREAK_EN
        brk_w   = 3'b000;
`endif
        for (int i = 0; i < NCH; i++) begin
            data_w[i] = 8'h00;
            mon_en[i] = 1'b1;
        end

        vecs[0] = '{0, 8'hA5, 10'b0101001011};
        vecs[1] = '{1, 8'h81, 10'b0100000011};
        vecs[2] = '{0, 8'h3C, 10'b0001111001};
        vecs[3] = '{2, 8'h55, 10'b0101010101};
        vecs[4] = '{1, 8'h00, 10'b0000000001};
        vecs[5] = '{0, 8'hFF, 10'b0111111111};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_w = 3'b000;
        #1;
        for (int i = 0; i < NCH; i++) begin
            check("reset_signal", i, 32'(signal_w[i]), 32'd1);
            check("reset_busy", i, 32'(busy_w[i]), 32'd0);
            check("reset_ready", i, 32'(ready_w[i]), 32'd1);
        end

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].ch, vecs[v].data, vecs[v].frame);
        end

        back_to_back();
        repeat (3) @(posedge clk);
        reset_mid_frame();
        backpressure();
        repeat (3) @(posedge clk);

        // Random traffic: valid gaps, changing data, occasional resets.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                valid_w[ch] = ($urandom_range(0, 3) != 0);
                data_w[ch]  = 8'($urandom);
                rst_w[ch]   = ($urandom_range(0, 299) == 0);
            end
        end
        @(negedge clk);
        valid_w = 3'b000;
        rst_w   = 3'b000;
        repeat (60) @(posedge clk);

`ifdef UART_TX_BREAK_EN
        @(negedge clk);
        mon_en[2] = 1'b0;
        break_pulse();
        repeat (4) @(posedge clk);
        break_mid_frame();
        repeat (4) @(posedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter producing the 8N1 frame accepted by the team's UART frame checker: idle-high line, one start bit (0), eight data bits LSB first, one stop bit (1). Bytes arrive over a ready/valid handshake from the host-side logic; the block drives the single-wire `signal` output toward the receiver. Bit period is programmable in clock cycles. With CLKS_PER_BIT=1 the output is cycle-compatible with the frame checker, including back-to-back frames.

## Interface
- CLKS_PER_BIT, 1: clock cycles per bit period; legal range 1..65535.
- BREAK_BITS, 11: minimum break length in bit periods; used only with UART_TX_BREAK_EN.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  8  byte to send; sampled only on a handshake.
- data_valid  input  1  `data` holds a byte to send.
- data_ready  output  1  block accepts a byte this cycle; handshake = data_valid & data_ready at the rising edge.
- signal  output  1  serial line, registered, idle high.
- busy  output  1  high in any state other than IDLE.
- send_break  input  1  request a line break; present only with UART_TX_BREAK_EN.

## Operation
- States: IDLE, START, DATA, STOP, plus BREAK and MARK with UART_TX_BREAK_EN.
- Registers:
  - shift register, 8 bits;
  - bit index, 3 bits, 0..7;
  - baud counter, 16 bits, 0..CLKS_PER_BIT-1.
- The baud counter wraps to 0 at CLKS_PER_BIT-1. A wrap marks the end of a bit period.
- IDLE: signal=1; data_ready=1. On a handshake, load the shift register from `data` and go to START with the baud counter at 0.
- START: signal=0 for one bit period, then go to DATA with bit index 0.
- DATA: signal=shift[0]. At each bit-period end, shift right and increment the bit index. After bit index 7, go to STOP.
- STOP: signal=1 for one bit period.
  - data_ready=1 only in the last cycle of STOP (baud counter = CLKS_PER_BIT-1).
  - Handshake in that cycle: load the byte and go to START. There is no idle gap.
  - Otherwise go to IDLE.
- `signal` is a registered copy of the state-decoded line value. A handshake at edge e puts the start bit on `signal` from edge e+1.
- data_ready is combinational from the state and the baud counter. It never depends on data_valid.
- When data_valid is held low, nothing is accepted.
- `data` is don't-care outside a handshake.
- An illegal state encoding returns to IDLE on the next edge, with signal=1.

## Timing
- Reset values: signal=1, busy=0, state IDLE, data_ready=1 in the first cycle after reset, counters 0.
- Reset asserted mid-frame: the frame is aborted, and signal=1 from the next edge. No partial byte is resumed.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the start bit to the end of the stop bit.
- Sustained throughput: one byte per 10*CLKS_PER_BIT cycles.
- At CLKS_PER_BIT=1, handshake at edge e gives the following line values:
  - e+1: start bit;
  - e+2..e+9: data[0]..data[7];
  - e+10: stop bit.
  - The next handshake is possible at edge e+10, whose start bit appears at e+11.

## Configuration
- UART_TX_BREAK_EN defined: adds the `send_break` port and the BREAK and MARK states.
  - Break request: in IDLE, or in the last cycle of STOP, send_break=1 takes priority over data. data_ready=0 whenever send_break=1.
  - BREAK: signal=0. Stay while send_break=1, and for at least BREAK_BITS bit periods in total.
  - MARK: entered from BREAK. signal=1 for exactly one bit period, then IDLE.
  - The receiver needs the line high to leave its own break state; MARK provides that.
  - A frame in progress always completes before a break starts.
- UART_TX_BREAK_EN undefined: no `send_break` port, no BREAK or MARK states, and BREAK_BITS is ignored.

## Test plan
- Single byte, CLKS_PER_BIT=1: send 0xA5 → signal = 0,1,0,1,0,0,1,0,1,1 on edges e+1..e+10; busy high for those 10 cycles, then back to IDLE with signal=1.
- Back-to-back bytes, CLKS_PER_BIT=1, data_valid held high: send 0x00 then 0xFF → 20 consecutive line bits 0,0×8,1,0,1×8,1 with no idle cycle; exactly two handshakes occur.
- Divided clock, CLKS_PER_BIT=4: send 0x81 → each bit held for exactly 4 cycles, frame spans 40 cycles, data_ready is low for cycles 1..39 of the frame.
- Reset mid-frame: assert reset during data bit 3 of 0x3C → signal=1, busy=0 from the next edge; a new byte 0x55 afterwards produces a clean frame.
- Backpressure: hold data_valid=1 and change `data` during a frame → only the value present at the last-STOP-cycle handshake is sent; the intermediate values never appear on the line.
- With UART_TX_BREAK_EN, CLKS_PER_BIT=2: pulse send_break for 1 cycle in IDLE → signal=0 for 22 cycles, then 1 for 2 cycles (MARK), then IDLE; a break requested mid-frame starts only after the stop bit.
